// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler
// Turns the raw PS/2 scancode level into debounced, one-shot game commands
// (LEFT/RIGHT/SELECT/START) and queues them in a small FIFO that the Uno
// engine drains with a valid/ready handshake. A START keypress flushes any
// stale queued moves and becomes the only queued entry.
module ps2_cmd_scheduler #(
  parameter logic [7:0] KEY_LEFT      = 8'h15,
  parameter logic [7:0] KEY_RIGHT     = 8'h24,
  parameter logic [7:0] KEY_SELECT    = 8'h5A,
  parameter logic [7:0] KEY_START     = 8'h76,
  parameter int         STABLE_CYCLES = 16,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_char,
  input  logic                          i_cmd_ready,
  input  logic                          i_clr_ovf,
  output logic                          o_cmd_valid,
  output logic [1:0]                    o_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [1:0]    CMD_START = 2'd3;

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  // Debounce filter state
  logic [7:0]    r_sample;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_filt;

  // Edge detector state
  state_t        r_state;
  logic [7:0]    r_key;

  // Command queue state
  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic [1:0]    r_cmd;
  logic          r_ovf;

  // Key lookup
  logic [7:0]    w_keys [4];
  logic [3:0]    w_hit;
  logic          w_match;
  logic [1:0]    w_match_cmd;

  // Queue control
  logic          w_push;
  logic          w_push_start;
  logic          w_push_move;
  logic          w_pop;
  logic          w_full;
  logic          w_wr_en;
  logic          w_ovf_set;
  logic [PW-1:0] w_wr_addr;
  logic [PW-1:0] w_rd_next;
  logic [PW-1:0] w_wr_next;
  logic [LW-1:0] w_rem;
  logic [LW-1:0] w_level_next;
  logic [1:0]    w_cmd_next;

  // Table index equals the command code
  assign w_keys[0] = KEY_LEFT;
  assign w_keys[1] = KEY_RIGHT;
  assign w_keys[2] = KEY_SELECT;
  assign w_keys[3] = KEY_START;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_hit
    assign w_hit[gi] = (r_filt == w_keys[gi]);
  end

  // Encode the matching key into its command code
  always_comb begin
    w_match     = |w_hit;
    w_match_cmd = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_hit[i]) w_match_cmd = 2'(i);
    end
  end

  // Debounce: the filtered code follows i_char only after it has held steady
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample <= 8'h00;
      r_cnt    <= '0;
      r_filt   <= 8'h00;
    end else if (i_char != r_sample) begin
      r_sample <= i_char;
      r_cnt    <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_filt   <= r_sample;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // A push fires on entry to a mapped key; the HELD state blocks re-triggers
  assign w_push       = (r_state == ST_IDLE) && w_match;
  assign w_push_start = w_push && (w_match_cmd == CMD_START);
  assign w_push_move  = w_push && !w_push_start;

  // Edge FSM: IDLE waits for a mapped key, HELD waits for the code to change
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_key   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            r_key   <= r_filt;
            r_state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (r_filt != r_key) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_valid = (r_level != '0);
  assign w_pop       = o_cmd_valid && i_cmd_ready;
  assign w_full      = (r_level == LVL_FULL);
  // A move may enter a full queue only when the head leaves in the same cycle
  assign w_wr_en     = w_push_start || (w_push_move && (!w_full || w_pop));
  assign w_ovf_set   = w_push_move && w_full && !w_pop;
  // START restarts the queue at slot 0
  assign w_wr_addr   = w_push_start ? '0 : r_wr_ptr;

  // Next pointers, level and registered head word (first-word fall-through)
  always_comb begin
    w_rd_next    = r_rd_ptr;
    w_wr_next    = r_wr_ptr;
    w_level_next = r_level;
    w_cmd_next   = r_cmd;
    w_rem        = r_level;
    if (w_push_start) begin
      w_rd_next    = '0;
      w_wr_next    = PW'(1);
      w_level_next = LW'(1);
      w_cmd_next   = CMD_START;
    end else begin
      if (w_pop) begin
        w_rd_next = r_rd_ptr + 1'b1;
        w_rem     = r_level - 1'b1;
      end
      if (w_wr_en) w_wr_next = r_wr_ptr + 1'b1;
      w_level_next = w_rem + {{(LW-1){1'b0}}, w_wr_en};
      // Surviving entries keep the head; otherwise the new push becomes it
      if (w_rem != '0) begin
        w_cmd_next = r_mem[w_rd_next];
      end else if (w_wr_en) begin
        w_cmd_next = w_match_cmd;
      end
    end
  end

  // Queue storage
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_match_cmd;
  end

  // Queue pointers, level, head register and sticky overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_cmd    <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= w_wr_next;
      r_level  <= w_level_next;
      r_cmd    <= w_cmd_next;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_cmd        = r_cmd;
  assign o_fifo_level = r_level;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// tb_ps2_cmd_scheduler
// Directed stimulus drives keypress sequences and pushes the expected commands
// into a scoreboard queue; a negedge monitor pops and compares every command
// the DUT hands over on a valid/ready handshake.
module tb_ps2_cmd_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] i_char;
  logic       i_cmd_ready;
  logic       i_clr_ovf;
  logic       o_cmd_valid;
  logic [1:0] o_cmd;
  logic [2:0] o_fifo_level;
  logic       o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] q [$];

  ps2_cmd_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_char       (i_char),
    .i_cmd_ready  (i_cmd_ready),
    .i_clr_ovf    (i_clr_ovf),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd        (o_cmd),
    .o_fifo_level (o_fifo_level),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step off the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stable press for 20 cycles then a 20-cycle release
  task automatic press(input logic [7:0] code, input bit exp_push, input logic [1:0] cmd);
    if (exp_push) q.push_back(cmd);
    i_char = code;
    cyc(20);
    i_char = 8'h00;
    cyc(20);
  endtask

  task automatic drain();
    i_cmd_ready = 1'b1;
    for (int k = 0; k < 10 && o_fifo_level != 0; k++) cyc(1);
    i_cmd_ready = 1'b0;
    check("drain_level", o_fifo_level, 0);
  endtask

  // Scoreboard monitor: compare each handed-over command with the model
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst && o_cmd_valid && i_cmd_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got cmd %0d, expected no entry", o_cmd);
      end else begin
        e = q.pop_front();
        $display("[TB] pop cmd=%0d expected=%0d", o_cmd, e);
        check("pop_cmd", o_cmd, e);
      end
    end
  end

  initial begin
    rst = 1'b1; i_char = 8'h00; i_cmd_ready = 1'b0; i_clr_ovf = 1'b0;
    cyc(3);
    rst = 1'b0;
    check("rst_valid", o_cmd_valid, 0);
    check("rst_cmd", o_cmd, 0);
    check("rst_level", o_fifo_level, 0);
    check("rst_ovf", o_overflow, 0);
    cyc(5);

    // Debounce: 15 cycles is one short of stable
    i_char = 8'h24;
    cyc(15);
    i_char = 8'h00;
    cyc(20);
    check("short_no_push", o_fifo_level, 0);
    q.push_back(2'd1);
    i_char = 8'h24;
    cyc(17);
    check("edge17_valid", o_cmd_valid, 0);
    cyc(1);
    check("edge18_valid", o_cmd_valid, 1);
    check("edge18_cmd", o_cmd, 1);
    cyc(22);
    check("hold_one_push", o_fifo_level, 1);
    i_char = 8'h00;
    cyc(20);
    drain();

    // Re-trigger rules: direct key change and re-press; long hold adds nothing
    q.push_back(2'd0); q.push_back(2'd2); q.push_back(2'd2);
    i_char = 8'h15; cyc(20);
    i_char = 8'h5A; cyc(20);
    i_char = 8'h00; cyc(20);
    i_char = 8'h5A; cyc(60);
    i_char = 8'h00; cyc(20);
    check("retrig_level", o_fifo_level, 3);
    drain();

    // Backpressure: five LEFTs into a depth-4 queue
    for (int i = 0; i < 5; i++) press(8'h15, (i < 4), 2'd0);
    check("ovf_level", o_fifo_level, 4);
    check("ovf_set", o_overflow, 1);
    check("ovf_head", o_cmd, 0);
    i_clr_ovf = 1'b1;
    cyc(1);
    i_clr_ovf = 1'b0;
    check("ovf_clear", o_overflow, 0);

    // Full queue with push and pop on the same edge
    q.push_back(2'd1);
    i_char = 8'h24;
    cyc(17);
    i_cmd_ready = 1'b1;
    cyc(1);
    i_cmd_ready = 1'b0;
    check("full_pp_level", o_fifo_level, 4);
    check("full_pp_ovf", o_overflow, 0);
    cyc(5);
    i_char = 8'h00;
    cyc(20);
    drain();

    // START flushes queued moves and overrides a same-cycle pop
    press(8'h15, 1'b1, 2'd0);
    press(8'h24, 1'b1, 2'd1);
    press(8'h5A, 1'b1, 2'd2);
    check("pre_start_level", o_fifo_level, 3);
    i_char = 8'h76;
    cyc(17);
    i_cmd_ready = 1'b1;
    cyc(1);
    i_cmd_ready = 1'b0;
    q.delete();
    q.push_back(2'd3);
    check("start_level", o_fifo_level, 1);
    check("start_cmd", o_cmd, 3);
    check("start_valid", o_cmd_valid, 1);
    check("start_ovf", o_overflow, 0);
    cyc(5);
    i_char = 8'h00;
    cyc(20);
    drain();

    // Reset mid-stream with two queued commands and a partial debounce
    press(8'h24, 1'b1, 2'd1);
    press(8'h15, 1'b1, 2'd0);
    check("prerst_level", o_fifo_level, 2);
    i_char = 8'h5A;
    cyc(8);
    rst = 1'b1;
    q.delete();
    #1;
    check("async_rst_level", o_fifo_level, 0);
    check("async_rst_cmd", o_cmd, 0);
    cyc(2);
    rst = 1'b0;
    check("midrst_valid", o_cmd_valid, 0);
    check("midrst_level", o_fifo_level, 0);
    check("midrst_ovf", o_overflow, 0);
    cyc(17);
    check("postrst_no_push", o_fifo_level, 0);
    q.push_back(2'd2);
    cyc(1);
    check("postrst_push", o_fifo_level, 1);
    check("postrst_cmd", o_cmd, 2);
    i_char = 8'h00;
    cyc(20);
    drain();

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
